// File: rtl/spi_slave_if_burst.sv
// SPI slave front-end: deserialises {cmd,payload} frames from MOSI and
// serialises RAM read data onto MISO, with read-address tracking and burst reads.
module spi_slave_if_burst #(
   parameter int DATA_W     = 8,
   parameter int BURST_EN   = 1,
   parameter int TX_TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              MOSI,
   input  logic              SS_n,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              MISO,
   output logic [DATA_W+1:0] rx_data,
   output logic              rx_valid,
   output logic              rd_err,
   output logic              busy
);
   localparam int FW = DATA_W + 2;
   localparam int CW = $clog2(FW + 1);
   localparam int TW = (TX_TIMEOUT > 0) ? $clog2(TX_TIMEOUT + 1) : 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RECV  = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_SEND  = 3'd3;
   localparam logic [2:0] S_BURST = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   logic [2:0]        state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [TW-1:0]     tmr_q, tmr_d;
   logic [FW-2:0]     sr_q, sr_d;
   logic [FW-1:0]     rx_data_q, rx_data_d;
   logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
   logic [DATA_W-1:0] rd_addr_q, rd_addr_d;
   logic              ok_q, ok_d;
   logic              miso_q, miso_d;
   logic              rxv_q, rxv_d;
   logic              err_q, err_d;
   logic [FW-1:0]     frame;
   logic              abort;

   // Frame as it stands once this edge's MOSI bit is shifted in.
   assign frame = {sr_q, MOSI};
   assign abort = SS_n && (state_q == S_RECV || state_q == S_WAIT ||
                           state_q == S_SEND || state_q == S_BURST);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      tmr_d     = tmr_q;
      sr_d      = sr_q;
      rx_data_d = rx_data_q;
      tx_sr_d   = tx_sr_q;
      rd_addr_d = rd_addr_q;
      ok_d      = ok_q;
      miso_d    = miso_q;
      rxv_d     = 1'b0;
      err_d     = 1'b0;
      if (abort) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         tmr_d   = '0;
         miso_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (!SS_n) begin
               sr_d    = frame[FW-2:0];
               cnt_d   = CW'(1);
               state_d = S_RECV;
            end
            S_RECV: begin
               sr_d  = frame[FW-2:0];
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(FW - 1)) begin
                  cnt_d = '0;
                  if (frame[FW-1:FW-2] == 2'b11) begin
                     if (ok_q) begin
                        rx_data_d = frame;
                        rxv_d     = 1'b1;
                        tmr_d     = '0;
                        state_d   = S_WAIT;
                     end else begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                     end
                  end else begin
                     rx_data_d = frame;
                     rxv_d     = 1'b1;
                     state_d   = S_DONE;
                     if (frame[FW-1:FW-2] == 2'b10) begin
                        rd_addr_d = frame[DATA_W-1:0];
                        ok_d      = 1'b1;
                     end
                  end
               end
            end
            S_WAIT: begin
               if (tx_valid) begin
                  tx_sr_d = tx_data << 1;
                  miso_d  = tx_data[DATA_W-1];
                  ok_d    = 1'b0;
                  cnt_d   = CW'(1);
                  tmr_d   = '0;
                  state_d = S_SEND;
               end else if (TX_TIMEOUT != 0) begin
                  if (tmr_q == TW'(TX_TIMEOUT - 1)) begin
                     err_d   = 1'b1;
                     tmr_d   = '0;
                     state_d = S_DONE;
                  end else begin
                     tmr_d = tmr_q + TW'(1);
                  end
               end
            end
            S_SEND: begin
               if (cnt_q != CW'(DATA_W)) begin
                  miso_d  = tx_sr_q[DATA_W-1];
                  tx_sr_d = tx_sr_q << 1;
                  cnt_d   = cnt_q + CW'(1);
               end else begin
                  miso_d = 1'b0;
                  cnt_d  = '0;
                  // SS_n is known low here, so a burst continues at the next address.
                  if (BURST_EN != 0) begin
                     rd_addr_d = rd_addr_q + DATA_W'(1);
                     rx_data_d = {2'b10, rd_addr_q + DATA_W'(1)};
                     rxv_d     = 1'b1;
                     ok_d      = 1'b1;
                     state_d   = S_BURST;
                  end else begin
                     state_d = S_DONE;
                  end
               end
            end
            S_BURST: begin
               rx_data_d = {2'b11, {DATA_W{1'b0}}};
               rxv_d     = 1'b1;
               tmr_d     = '0;
               state_d   = S_WAIT;
            end
            S_DONE: if (SS_n) state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         tmr_q     <= '0;
         sr_q      <= '0;
         rx_data_q <= '0;
         tx_sr_q   <= '0;
         rd_addr_q <= '0;
         ok_q      <= 1'b0;
         miso_q    <= 1'b0;
         rxv_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         tmr_q     <= tmr_d;
         sr_q      <= sr_d;
         rx_data_q <= rx_data_d;
         tx_sr_q   <= tx_sr_d;
         rd_addr_q <= rd_addr_d;
         ok_q      <= ok_d;
         miso_q    <= miso_d;
         rxv_q     <= rxv_d;
         err_q     <= err_d;
      end
   end

   assign MISO     = miso_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rxv_q;
   assign rd_err   = err_q;
   assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_slave_if_burst.sv
// Scoreboard bench for spi_slave_if_burst: stimulus pushes expected events,
// a monitor pops them whenever rx_valid/rd_err fire or a MISO word is due.
module tb_spi_slave_if_burst;
   localparam int DW = 8;
   localparam int FW = DW + 2;

   logic          clk = 1'b0, rst_n = 1'b0, MOSI = 1'b0, SS_n = 1'b1, tx_valid = 1'b0;
   logic [DW-1:0] tx_data = '0;
   logic          MISO, rx_valid, rd_err, busy;
   logic [FW-1:0] rx_data;

   typedef struct { bit err; logic [FW-1:0] data; } exp_t;
   exp_t          exp_q[$];
   logic [DW-1:0] miso_q[$];
   int            ncmp = 0, nfail = 0;
   bit            tx_arm = 1'b0, miso_chk = 1'b1;

   spi_slave_if_burst #(.DATA_W(DW), .BURST_EN(1), .TX_TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n), .MOSI(MOSI), .SS_n(SS_n),
      .tx_data(tx_data), .tx_valid(tx_valid), .MISO(MISO),
      .rx_data(rx_data), .rx_valid(rx_valid), .rd_err(rd_err), .busy(busy));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic push_rx(input logic [FW-1:0] d);
      exp_t e; e.err = 1'b0; e.data = d; exp_q.push_back(e);
   endtask

   task automatic push_err();
      exp_t e; e.err = 1'b1; e.data = '0; exp_q.push_back(e);
   endtask

   task automatic send_frame(input logic [FW-1:0] w, input bit keep);
      for (int i = FW - 1; i >= 0; i--) begin
         @(negedge clk); SS_n = 1'b0; MOSI = w[i];
      end
      if (!keep) begin
         @(negedge clk); SS_n = 1'b1; MOSI = 1'b0;
         repeat (2) @(negedge clk);
      end
   endtask

   // Wait (bounded) for the read-data pulse, leaving us just after that edge.
   task automatic wait_rd_pulse();
      int n = 0; bit seen = 1'b0;
      while (!seen && n < 100) begin
         @(posedge clk); #1; n++;
         if (rx_valid && rx_data[FW-1 -: 2] == 2'b11) seen = 1'b1;
      end
      chk("rd_pulse_seen", {31'd0, seen}, 32'd1);
   endtask

   // RAM answers 2 cycles after the read-data pulse; optionally end the burst.
   task automatic ram_reply(input logic [DW-1:0] d, input bit last);
      wait_rd_pulse();
      repeat (3) @(negedge clk);
      tx_data = d; tx_valid = 1'b1; tx_arm = 1'b1; miso_q.push_back(d);
      @(negedge clk); tx_valid = 1'b0; tx_arm = 1'b0;
      if (last) begin
         repeat (7) @(negedge clk);
         SS_n = 1'b1;
         repeat (3) @(negedge clk);
      end
   endtask

   initial begin : monitor
      exp_t          e;
      logic [DW-1:0] mword = '0;
      int            mcnt = 0;
      forever begin
         @(posedge clk); #1;
         if (rx_valid || rd_err) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_event", {30'd0, rx_valid, rd_err}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("event", {20'd0, rx_valid, rd_err, (rx_valid ? rx_data : {FW{1'b0}})},
                   {20'd0, ~e.err, e.err, (e.err ? {FW{1'b0}} : e.data)});
            end
         end
         if (mcnt != 0) begin
            if (mcnt < DW) chk("miso_bit", {31'd0, MISO}, {31'd0, mword[DW-1-mcnt]});
            else           chk("miso_tail", {31'd0, MISO}, 32'd0);
            mcnt = (mcnt == DW) ? 0 : mcnt + 1;
         end else if (tx_valid && tx_arm && miso_q.size() != 0) begin
            mword = miso_q.pop_front();
            chk("miso_bit", {31'd0, MISO}, {31'd0, mword[DW-1]});
            mcnt = 1;
         end else if (miso_chk && rst_n) begin
            chk("miso_idle", {31'd0, MISO}, 32'd0);
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int n;
      repeat (3) @(negedge clk);
      chk("rst_miso", {31'd0, MISO}, 32'd0);
      chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
      chk("rst_rx_data", {22'd0, rx_data}, 32'd0);
      chk("rst_rd_err", {31'd0, rd_err}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // write address / write data
      push_rx(10'h03C); send_frame(10'h03C, 1'b0);
      push_rx(10'h1A5); send_frame(10'h1A5, 1'b0);

      // tx_valid while idle must not reach MISO
      tx_data = 8'hFF; tx_valid = 1'b1;
      repeat (2) @(negedge clk);
      tx_valid = 1'b0;
      repeat (2) @(negedge clk);

      // read data with no address loaded
      push_err(); send_frame(10'h300, 1'b0);

      // single read
      push_rx(10'h210); send_frame(10'h210, 1'b0);
      push_rx(10'h300); send_frame(10'h300, 1'b1);
      ram_reply(8'hC3, 1'b1);

      // burst read of three words
      push_rx(10'h210); send_frame(10'h210, 1'b0);
      push_rx(10'h300);
      push_rx(10'h211); push_rx(10'h300);
      push_rx(10'h212); push_rx(10'h300);
      send_frame(10'h300, 1'b1);
      ram_reply(8'h5A, 1'b0);
      ram_reply(8'h96, 1'b0);
      ram_reply(8'h3E, 1'b1);

      // tx_valid timeout
      push_rx(10'h210); send_frame(10'h210, 1'b0);
      push_rx(10'h300); push_err();
      send_frame(10'h300, 1'b1);
      @(posedge clk);
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (!rd_err && n < 40);
      chk("timeout_latency", n, 32'd16);
      @(negedge clk); SS_n = 1'b1;
      repeat (3) @(negedge clk);

      // abort after 5 bits, then a clean frame
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); SS_n = 1'b0; MOSI = i[0];
      end
      @(negedge clk);
      chk("abort_busy_before", {31'd0, busy}, 32'd1);
      SS_n = 1'b1;
      @(posedge clk); #1;
      chk("abort_busy_after", {31'd0, busy}, 32'd0);
      repeat (2) @(negedge clk);
      push_rx(10'h0C3); send_frame(10'h0C3, 1'b0);

      // asynchronous reset in the middle of SEND
      miso_chk = 1'b0;
      push_rx(10'h300); send_frame(10'h300, 1'b1);
      wait_rd_pulse();
      repeat (3) @(negedge clk);
      tx_data = 8'hFF; tx_valid = 1'b1;
      @(negedge clk); tx_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("send_miso_pre_rst", {31'd0, MISO}, 32'd1);
      chk("send_busy_pre_rst", {31'd0, busy}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_miso", {31'd0, MISO}, 32'd0);
      chk("rst_mid_busy", {31'd0, busy}, 32'd0);
      chk("rst_mid_rx_data", {22'd0, rx_data}, 32'd0);
      @(negedge clk); rst_n = 1'b1; SS_n = 1'b1;
      repeat (2) @(negedge clk);
      miso_chk = 1'b1;

      repeat (5) @(negedge clk);
      chk("exp_q_drained", exp_q.size(), 32'd0);
      chk("miso_q_drained", miso_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", ncmp, nfail);
      $finish;
   end
endmodule

// File: doc/spi_slave_if_burst.md
# spi_slave_if_burst

Parametrised SPI slave front-end between an external SPI master and the on-chip RAM controller. It deserialises MOSI frames of `DATA_W`+2 bits into `rx_data`/`rx_valid` words. It serialises RAM read data from `tx_data` onto MISO. It adds read-address tracking, auto-increment burst reads, a tx_valid timeout and an error pulse.

## Interface

- `DATA_W`, default 8: address/data payload width; frame width `FW` = `DATA_W`+2.
- `BURST_EN`, default 1: 1 allows back-to-back read-data words while SS_n stays low.
- `TX_TIMEOUT`, default 16: maximum number of WAIT_TX cycles before abort; 0 waits forever.
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `MOSI` in 1: serial data from the master, MSB first, one bit per `clk`.
- `SS_n` in 1: slave select, active low.
- `tx_data` in `DATA_W`: read data from the RAM.
- `tx_valid` in 1: `tx_data` is valid this cycle.
- `MISO` out 1: serial data to the master, registered.
- `rx_data` out `FW`: {cmd[1:0], payload}, registered.
- `rx_valid` out 1: one-cycle pulse; `rx_data` is valid.
- `rd_err` out 1: one-cycle pulse on a protocol or timeout error.
- `busy` out 1: high when state != IDLE.

## Operation

- Commands (`rx_data[FW-1:FW-2]`): 00 = write address, 01 = write data, 10 = read address, 11 = read data.
- Internal registers: `rd_addr` (`DATA_W` bits) and `rd_addr_ok` flag; both are cleared by reset only, except that `rd_addr_ok` is also cleared on tx_data capture.
- State IDLE:
  - On an edge with SS_n low, shift MOSI in as frame bit FW-1, set count=1 and go to RECV.
- State RECV:
  - Shift one bit per edge.
  - The edge sampling bit FW (count reaching FW) completes the frame.
  - Commands 00, 01 and 10: load `rx_data`, pulse `rx_valid`, then go to DONE. Command 10 also loads `rd_addr` and sets `rd_addr_ok`.
  - Command 11 with `rd_addr_ok`=1: load `rx_data`, pulse `rx_valid`, then go to WAIT_TX.
  - Command 11 with `rd_addr_ok`=0: no `rx_valid`; pulse `rd_err`, then go to DONE.
- State WAIT_TX:
  - On an edge with tx_valid=1: capture `tx_data`, drive MISO<=tx_data[DATA_W-1], clear `rd_addr_ok`, go to SEND with bit index 1.
  - If the timeout counter reaches `TX_TIMEOUT` (nonzero) without tx_valid: pulse `rd_err` and go to DONE.
- State SEND:
  - Each edge drives the next bit, MSB first, until all DATA_W bits have each been held one cycle.
  - The following edge sets MISO<=0.
  - If `BURST_EN` and SS_n low: `rd_addr`<=`rd_addr`+1 (wraps mod 2^DATA_W), rx_data<={2'b10, rd_addr+1}, rx_valid pulse, set `rd_addr_ok`, go to BURST.
  - Otherwise go to DONE.
- State BURST: next edge rx_data<={2'b11, 0}, rx_valid pulse, go to WAIT_TX.
- State DONE: ignore MOSI; go to IDLE on the first edge with SS_n high.
- Abort: SS_n high in RECV, WAIT_TX, SEND or BURST returns to IDLE on that edge.
  - Clears count and timer and sets MISO to 0.
  - No `rx_valid` for a partial frame.
  - `rd_addr` and `rd_addr_ok` are kept.
- Reset values: MISO=0, rx_data=0, rx_valid=0, rd_err=0, busy=0, state=IDLE, count=0, rd_addr=0, rd_addr_ok=0.

## Timing

- Frame reception: first bit sampled on the first edge with SS_n low; last bit on edge FW.
- `rx_valid`/`rx_data` are high/valid for exactly the cycle after edge FW.
- Read-data latency: MISO MSB becomes visible the cycle after the tx_valid edge. The RAM may assert tx_valid as early as the cycle in which `rx_valid` is high.
- tx_valid outside WAIT_TX is ignored.
- Burst gap: the read-address pulse and the read-data pulse come on consecutive cycles, immediately after the last MISO bit cycle.
- Counters are sized `$clog2(FW+1)` bits and the timer `$clog2(TX_TIMEOUT+1)` bits; neither wraps.
- Asynchronous `rst_n` assertion mid-frame forces all reset values immediately, with no partial `rx_valid`.

## Test plan

- **Write sequence.** DATA_W=8, send 00_0x3C then 01_0xA5 with SS_n toggled high between frames.
  - Expect `rx_valid` pulses with rx_data=0x03C then 0x1A5, and MISO stays 0.
- **Single read.** Send 10_0x10; then 11_xx; the RAM returns tx_valid 2 cycles after `rx_valid` with 0xC3.
  - Expect MISO=1,1,0,0,0,0,1,1 on 8 consecutive cycles, then 0.
- **Burst read.** As the single read, but hold SS_n low for 3 words.
  - Expect `rx_valid` pulses 0x211, 0x300, 0x212, 0x300, and three MISO words in order.
- **Error: no address.** After reset, send 11_0x00.
  - Expect no `rx_valid` and a single `rd_err` pulse.
- **Error: timeout.** TX_TIMEOUT=16 and tx_valid never asserted.
  - Expect `rd_err` 16 cycles after WAIT_TX entry, and MISO=0.
- **Abort and reset.** Raise SS_n after 5 bits: expect no `rx_valid` and IDLE next cycle. Separately, assert rst_n low mid-SEND: expect MISO=0 and busy=0 immediately.
